serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder built around one full-adder cell (instantiated as full_adder) plus a registered carry.
- Accepts two parallel operands and a carry-in, processes one bit per clock LSB-first, then presents the parallel sum, carry-out and a one-cycle done pulse.
- Sits directly around the 1-bit full adder: it feeds the cell's a/b/carry inputs and consumes its sum/carry outputs each cycle.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start_in  input  1  request to begin an addition; sampled only in IDLE
- a_in  input  WIDTH  operand A; captured on the accepted start edge
- b_in  input  WIDTH  operand B; captured on the accepted start edge
- c_in  input  1  carry-in; captured on the accepted start edge
- busy_out  output  1  high while an addition is in progress (state ADD)
- done_out  output  1  one-cycle pulse marking a valid new result
- sum_out  output  WIDTH  registered result; holds until the next completion
- carry_out  output  1  registered final carry; holds until the next completion

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE. Shift registers, carry register and bit counter clear. busy_out=0, done_out=0, sum_out=0, carry_out=0.
- States: IDLE, ADD.
- IDLE with start_in=1 at a clock edge:
  - load a_sr<=a_in, b_sr<=b_in, carry_q<=c_in, count<=0
  - state<=ADD, busy_out<=1
- IDLE with start_in=0: hold. Inputs a_in/b_in/c_in are ignored.
- ADD, every edge:
  - full_adder inputs: a=a_sr[0], b=b_sr[0], c=carry_q
  - a_sr and b_sr shift right by 1
  - the sum bit shifts into the MSB of s_sr, so after WIDTH shifts s_sr[0] holds bit 0
  - carry_q<=full-adder carry; count<=count+1
- ADD exit: on the edge processing bit WIDTH-1 (count==WIDTH-1):
  - sum_out<={fa_sum, s_sr[WIDTH-1:1]}, carry_out<=fa_carry
  - done_out<=1, busy_out<=0, state<=IDLE
- done_out is high for exactly one cycle, then returns to 0 unless another completion occurs.
- Latency: start sampled at edge N; result and done_out valid after edge N+WIDTH. Throughput is one addition per WIDTH+1 cycles with back-to-back starts.
- start_in while busy (ADD): ignored, no effect on operands or count.
- start_in high during the done_out cycle: accepted, since state is IDLE. The new operation begins while sum_out still holds the previous result.
- Arithmetic: {carry_out,sum_out} == a_in + b_in + c_in, computed as modulo 2^(WIDTH+1) with no truncation of the carry.
- Counter width is $clog2(WIDTH), with no wrap beyond WIDTH-1.
- Reset asserted mid-ADD: operation aborts immediately.
  - Outputs go to reset values; the previous sum_out is lost.
  - No done_out pulse is produced for the aborted operation.
- Operand inputs need only be valid on the start edge.

Test Plan:
- WIDTH=8, a=8'hFF, b=8'h01, c=0, start one cycle -> busy_out high 8 cycles; done_out pulses once 8 cycles after start; sum_out=8'h00, carry_out=1.
- a=8'h5A, b=8'hA5, c=1 -> sum_out=8'h00, carry_out=1. Then a=8'h00, b=8'h00, c=0 -> sum_out=8'h00, carry_out=0; done_out pulses each time.
- a=8'h12, b=8'h34, c=0 started; at cycle 3, start_in=1 with a=8'hFF, b=8'hFF -> second start ignored; result sum_out=8'h46, carry_out=0.
- start_in held high continuously with fixed a=8'h80, b=8'h80, c=1 -> done_out every 9 cycles; each result sum_out=8'h01, carry_out=1.
- a=8'hF0, b=8'h0F started; rst_n pulsed low at cycle 4 -> busy_out, done_out, sum_out, carry_out all 0 immediately; no done_out afterwards. A new start with a=8'h01, b=8'h02 yields 8'h03.
- Randomized-operand self-check over 1000 operations for WIDTH=8 and WIDTH=16 -> {carry_out,sum_out} matches a+b+c on every done_out, and done_out never lasts longer than 1 cycle.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder built around a single full-adder cell.
// Operands are captured on an accepted start, added one bit per clock
// LSB-first, and the parallel sum/carry are presented with a one-cycle
// done pulse. The final sum and carry stay registered until the next
// completion.

// One-bit full adder; the only arithmetic in the design.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        ADD
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic [WIDTH-1:0] s_sr_next;
    logic             carry_q;
    logic [CNT_W-1:0] count;

    logic             fa_sum;
    logic             fa_carry;

    logic             load;
    logic             shift;
    logic             finish;

    // The cell always sees the current LSBs and the running carry; its
    // outputs only matter while the FSM is in ADD.
    full_adder u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign s_sr_next = (s_sr >> 1) | ({{(WIDTH-1){1'b0}}, fa_sum} << (WIDTH - 1));

    // Busy is a pure decode of the state register, so it is glitch-free.
    assign busy_out = (state == ADD);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) begin
                    load       = 1'b1;
                    state_next = ADD;
                end
            end
            ADD: begin
                shift = 1'b1;
                if (count == LAST) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand/sum shift registers, carry, bit counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the shift registers are plain flops, not a memory, so they
        // take the asynchronous reset like everything else; an abort leaves
        // no stale partial sum behind.
        if (!rst_n) begin
            a_sr      <= '0;
            b_sr      <= '0;
            s_sr      <= '0;
            carry_q   <= 1'b0;
            count     <= '0;
            sum_out   <= '0;
            carry_out <= 1'b0;
            done_out  <= 1'b0;
        end else begin
            done_out <= 1'b0;
            if (load) begin
                a_sr    <= a_in;
                b_sr    <= b_in;
                carry_q <= c_in;
                count   <= '0;
            end
            if (shift) begin
                a_sr    <= a_sr >> 1;
                b_sr    <= b_sr >> 1;
                s_sr    <= s_sr_next;
                carry_q <= fa_carry;
                count   <= finish ? '0 : count + 1'b1;
            end
            if (finish) begin
                sum_out   <= s_sr_next;
                carry_out <= fa_carry;
                done_out  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16.
// Directed vectors come from a table, multi-cycle corner cases are
// hand-sequenced, and random operands are checked against plain a+b+c.
module tb_serial_adder;

    logic        clk;
    logic        rst_n;

    logic        start8;
    logic [7:0]  a8, b8;
    logic        c8;
    logic        busy8, done8;
    logic [7:0]  sum8;
    logic        carry8;

    logic        start16;
    logic [15:0] a16, b16;
    logic        c16;
    logic        busy16, done16;
    logic [15:0] sum16;
    logic        carry16;

    int n_cmp = 0;
    int n_bad = 0;

    int done_cnt8  = 0;
    int done_cnt16 = 0;
    int long8      = 0;
    int long16     = 0;
    logic pd8  = 1'b0;
    logic pd16 = 1'b0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t vecs[8];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_in  (start8),
        .a_in      (a8),
        .b_in      (b8),
        .c_in      (c8),
        .busy_out  (busy8),
        .done_out  (done8),
        .sum_out   (sum8),
        .carry_out (carry8)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_in  (start16),
        .a_in      (a16),
        .b_in      (b16),
        .c_in      (c16),
        .busy_out  (busy16),
        .done_out  (done16),
        .sum_out   (sum16),
        .carry_out (carry16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counting and pulse-width watch on done.
    always @(negedge clk) begin
        if (done8) done_cnt8++;
        if (done8 && pd8) long8++;
        pd8 = done8;
        if (done16) done_cnt16++;
        if (done16 && pd16) long16++;
        pd16 = done16;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait (bounded) at negedges for done; lat is the negedge index after the start edge.
    task automatic wait_done(input int w, input int lat0, output int lat, output int busy_cnt,
                             output logic d, output logic bz);
        lat      = lat0;
        busy_cnt = 0;
        forever begin
            d  = (w == 8) ? done8 : done16;
            bz = (w == 8) ? busy8 : busy16;
            if (d || lat >= 4 * w) break;
            if (bz) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    // One full operation with latency, busy-length and result checks.
    task automatic op(input int w, input logic [31:0] a, input logic [31:0] b, input logic c,
                      input logic [32:0] exp, input string name);
        int lat, busy_cnt;
        logic d, bz;
        logic [32:0] act;
        @(negedge clk);
        if (w == 8) begin
            start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; c8 = c;
        end else begin
            start16 = 1'b1; a16 = a[15:0]; b16 = b[15:0]; c16 = c;
        end
        @(negedge clk);
        // Operands only need to be valid on the start edge.
        start8 = 1'b0; a8 = ~a8; b8 = ~b8; c8 = ~c8;
        start16 = 1'b0; a16 = ~a16; b16 = ~b16; c16 = ~c16;
        wait_done(w, 1, lat, busy_cnt, d, bz);
        act = (w == 8) ? {24'b0, carry8, sum8} : {16'b0, carry16, sum16};
        check({name, " done"}, 64'(d), 64'(1));
        check({name, " latency"}, 64'(lat), 64'(w + 1));
        check({name, " busy cycles"}, 64'(busy_cnt), 64'(w));
        check({name, " busy at done"}, 64'(bz), 64'(0));
        check({name, " result"}, 64'(act), 64'(exp));
    endtask

    initial begin
        int lat, busy_cnt, prev_t, n_done, cnt_before;
        logic d, bz;
        logic [31:0] ra, rb;
        logic        rc;
        logic [32:0] model;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[4] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0};
        vecs[5] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[7] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy8", 64'(busy8), 64'(0));
        check("reset done8", 64'(done8), 64'(0));
        check("reset sum8", 64'({carry8, sum8}), 64'(0));
        check("reset sum16", 64'({busy16, done16, carry16, sum16}), 64'(0));
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            op(8, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].c,
               33'({vecs[i].co, vecs[i].s}), $sformatf("vec%0d", i));
        end
        op(16, 32'hFFFF, 32'h0001, 1'b0, 33'h1_0000, "w16 carry ripple");

        // Start while busy is ignored.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; c8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done(8, 4, lat, busy_cnt, d, bz);
        check("busy start done", 64'(d), 64'(1));
        check("busy start latency", 64'(lat), 64'(9));
        check("busy start result", 64'({carry8, sum8}), 64'(9'h046));

        // Start held high: a new operation every WIDTH+1 cycles.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; c8 = 1'b1;
        prev_t = 0;
        n_done = 0;
        for (int t = 1; t <= 45; t++) begin
            @(negedge clk);
            if (done8) begin
                n_done++;
                check("stream gap", 64'(t - prev_t), 64'(9));
                check("stream result", 64'({carry8, sum8}), 64'(9'h101));
                prev_t = t;
            end
        end
        check("stream done count", 64'(n_done), 64'(5));
        start8 = 1'b0;
        for (int t = 0; t < 20 && (busy8 || done8); t++) @(negedge clk);
        check("stream drained", 64'(busy8), 64'(0));

        // Reset mid-operation aborts with no done pulse.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F; c8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-abort busy", 64'(busy8), 64'(1));
        rst_n = 1'b0;
        #1;
        check("abort busy", 64'(busy8), 64'(0));
        check("abort done", 64'(done8), 64'(0));
        check("abort sum", 64'(sum8), 64'(0));
        check("abort carry", 64'(carry8), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cnt_before = done_cnt8;
        repeat (15) @(negedge clk);
        check("abort no done", 64'(done_cnt8), 64'(cnt_before));
        op(8, 32'h01, 32'h02, 1'b0, 33'h003, "after abort");

        // Random operands against a+b+c.
        for (int w = 8; w <= 16; w += 8) begin
            for (int i = 0; i < 1000; i++) begin
                ra = $urandom & ((32'h1 << w) - 1);
                rb = $urandom & ((32'h1 << w) - 1);
                rc = 1'($urandom_range(0, 1));
                model = 33'(ra) + 33'(rb) + 33'(rc);
                op(w, ra, rb, rc, model, $sformatf("rand w%0d #%0d", w, i));
            end
        end

        check("done8 width", 64'(long8), 64'(0));
        check("done16 width", 64'(long16), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
